// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory read bus used by the fetch controller.
// Handshake: the master raises imem_req with imem_addr and keeps imem_addr stable
// until imem_ack; a word is transferred in every cycle where imem_req and imem_ack
// are both high, and imem_rdata is only meaningful in that cycle.
interface if_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: reads one word per request from instruction memory,
// steps the PC register only when a word is handed to decode (or on a redirect),
// parks a word in a one-entry buffer while decode stalls, and discards the data of
// a request that was overtaken by a branch/jump redirect.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_q,
    input  logic [31:0]           pc_d,
    output logic                  pc_nen,
    if_fetch_ctrl_if.master       imem,
    input  logic                  id_stall,
    input  logic                  redirect,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_valid,
    output logic                  dbg_state
);

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_req_addr;
    logic        r_drop;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic [31:0] r_buf;
    logic [31:0] r_buf_pc;

    state_t      w_state_nxt;
    logic [31:0] w_req_addr_nxt;
    logic        w_drop_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_instr_pc_nxt;
    logic        w_instr_valid_nxt;
    logic [31:0] w_buf_nxt;
    logic [31:0] w_buf_pc_nxt;
    logic        w_advance;
    logic        w_imem_req;

    // Next-state and decoded outputs; every register holds unless a rule below fires.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_addr_nxt = r_req_addr;
        w_drop_nxt     = r_drop;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_buf_nxt      = r_buf;
        w_buf_pc_nxt   = r_buf_pc;
        w_advance      = 1'b0;
        w_imem_req     = 1'b0;

        case (r_state)
            ST_REQ: begin
                w_imem_req = 1'b1;
                if (imem.imem_ack) begin
                    if (r_drop || redirect) begin
                        // Stale word: refetch from wherever the PC now points.
                        w_drop_nxt     = 1'b0;
                        w_req_addr_nxt = redirect ? pc_d : pc_q;
                    end else if (id_stall) begin
                        w_buf_nxt    = imem.imem_rdata;
                        w_buf_pc_nxt = r_req_addr;
                        w_state_nxt  = ST_HOLD;
                    end else begin
                        w_advance      = 1'b1;
                        w_instr_nxt    = imem.imem_rdata;
                        w_instr_pc_nxt = r_req_addr;
                        w_req_addr_nxt = pc_d;
                    end
                end else if (redirect) begin
                    // Address must stay put until the ack, so remember to drop it.
                    w_drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_req_addr_nxt = pc_d;
                    w_state_nxt    = ST_REQ;
                end else if (!id_stall) begin
                    w_advance      = 1'b1;
                    w_instr_nxt    = r_buf;
                    w_instr_pc_nxt = r_buf_pc;
                    w_req_addr_nxt = pc_d;
                    w_state_nxt    = ST_REQ;
                end
            end
        endcase

        // Flush beats stall, stall holds, otherwise valid only on a hand-off.
        if (redirect) begin
            w_instr_valid_nxt = 1'b0;
        end else if (id_stall) begin
            w_instr_valid_nxt = r_instr_valid;
        end else begin
            w_instr_valid_nxt = w_advance;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_REQ;
            r_req_addr    <= RESET_PC;
            r_drop        <= 1'b0;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_buf         <= 32'h0;
            r_buf_pc      <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_drop        <= w_drop_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_buf         <= w_buf_nxt;
            r_buf_pc      <= w_buf_pc_nxt;
        end
    end

    assign pc_nen         = ~(w_advance | redirect);
    assign imem.imem_req  = w_imem_req;
    assign imem.imem_addr = r_req_addr;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign instr_valid    = r_instr_valid;
    assign dbg_state      = r_state;

endmodule
